div_ctrl_fsm: RTL

//   Control FSM for the restoring unsigned divider; sits directly upstream of the divider datapath.
//   - Accepts a start request and sequences the datapath control strobes (load/shift/add-sub/count/clear).
//   - Consumes the datapath status bits R_out (remainder sign) and z_cnt (count == 0).
//   - Reports completion through a busy/done handshake.

---
 rtl/div_ctrl_fsm.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/div_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// div_ctrl_fsm
//   Moore control FSM for a restoring unsigned divider. After a start request
//   it sequences the datapath strobes: load, then per bit shift, trial
//   subtract, quotient-bit capture, optional restore and counter decrement.
//   A final Q shift inserts the last quotient bit, and DONE pulses o_done.
//
//   Optional feature (macro DIV_ZERO_CHK_EN):
//     defined   - a start with i_b_zero=1 goes straight from IDLE to DONE and
//                 raises o_err with o_done. No datapath strobes are issued.
//     undefined - i_b_zero is ignored and o_err is tied to 0.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           start request, sampled in IDLE only
//   i_b_zero          divisor == 0 (only used with DIV_ZERO_CHK_EN)
//   R_out             remainder MSB (1 = negative after subtract)
//   z_cnt             datapath iteration counter == 0
//   load_b, load_q    capture divisor / dividend
//   enable_q,enable_r shift quotient / remainder left
//   load_r            load remainder from adder sum
//   add_enable        adder mode: 1 = R+B, 0 = R-B
//   shift_en_q        capture quotient bit (~R_out) into its DFF
//   load_cnt          decrement iteration counter
//   clr_nn            active-low counter preset to N
//   clr_d, clr_ADD,
//   clr_Reg_r         clear quotient-bit DFF / adder output / remainder
//   o_busy            high from LOAD through FINAL
//   o_done            one-cycle completion pulse (DONE)
//   o_err             divide-by-zero flag, valid with o_done
// ----------------------------------------------------------------------------
module div_ctrl_fsm #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned COUNT_WIDTH = 3,
    parameter int unsigned STATE_WID   = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_b_zero,
    input  logic R_out,
    input  logic z_cnt,
    output logic load_b,
    output logic load_q,
    output logic enable_q,
    output logic enable_r,
    output logic load_r,
    output logic add_enable,
    output logic shift_en_q,
    output logic load_cnt,
    output logic clr_nn,
    output logic clr_d,
    output logic clr_ADD,
    output logic clr_Reg_r,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);

    // The datapath counter must hold N, and 10 states need 4 bits.
    if (COUNT_WIDTH < $clog2(DATA_WIDTH + 1) || STATE_WID < 4) begin : g_param_chk
        $error("div_ctrl_fsm: COUNT_WIDTH or STATE_WID too small");
    end

    typedef enum logic [STATE_WID-1:0] {
        StIdle,
        StLoad,
        StShift,
        StSub,
        StCheck,
        StRestore,
        StDec,
        StZchk,
        StFinal,
        StDone
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    logic zero_start;
`ifdef DIV_ZERO_CHK_EN
    assign zero_start = i_b_zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = i_b_zero;
    assign zero_start    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        load_b     = 1'b0;
        load_q     = 1'b0;
        enable_q   = 1'b0;
        enable_r   = 1'b0;
        load_r     = 1'b0;
        add_enable = 1'b0;
        shift_en_q = 1'b0;
        load_cnt   = 1'b0;
        clr_nn     = 1'b1;
        clr_d      = 1'b0;
        clr_ADD    = 1'b0;
        clr_Reg_r  = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = zero_start ? StDone : StLoad;
                end
            end
            StLoad: begin
                load_b    = 1'b1;
                load_q    = 1'b1;
                clr_Reg_r = 1'b1;
                clr_d     = 1'b1;
                clr_ADD   = 1'b1;
                clr_nn    = 1'b0;
                o_busy    = 1'b1;
                state_d   = StShift;
            end
            StShift: begin
                enable_r = 1'b1;
                enable_q = 1'b1;
                o_busy   = 1'b1;
                state_d  = StSub;
            end
            StSub: begin
                load_r  = 1'b1;
                o_busy  = 1'b1;
                state_d = StCheck;
            end
            StCheck: begin
                shift_en_q = 1'b1;
                o_busy     = 1'b1;
                state_d    = R_out ? StRestore : StDec;
            end
            StRestore: begin
                load_r     = 1'b1;
                add_enable = 1'b1;
                o_busy     = 1'b1;
                state_d    = StDec;
            end
            StDec: begin
                load_cnt = 1'b1;
                o_busy   = 1'b1;
                state_d  = StZchk;
            end
            StZchk: begin
                o_busy  = 1'b1;
                state_d = z_cnt ? StFinal : StShift;
            end
            StFinal: begin
                // Pushes the last captured quotient bit into Q.
                enable_q = 1'b1;
                o_busy   = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef DIV_ZERO_CHK_EN
    // Remembers whether the accepted start was a divide-by-zero.
    logic err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && i_start) begin
            err_q <= i_b_zero;
        end
    end

    assign o_err = (state_q == StDone) && err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
